// File: rtl/spi_master_tx_fifo_if.sv
// spi_master_tx_fifo_if: APB write-strobe side and SPI controller valid/ready side of the TX FIFO.
interface spi_master_tx_fifo_if #(parameter int DATA_WIDTH = 32);
  logic                  wr_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  modport master (output wr_i, wr_data_i, ready_i, input data_o, valid_o);
  modport slave (input wr_i, wr_data_i, ready_i, output data_o, valid_o);
endinterface

// File: rtl/spi_master_tx_fifo.sv
// spi_master_tx_fifo: APB-fed TX word buffer for the SPI master controller with watermark irq and sticky overflow.
// Define SPI_TXFIFO_BYPASS_EN to pass a write straight to the controller when the FIFO is empty.
module spi_master_tx_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr_i,
  input  logic                      ovf_clr_i,
  input  logic [LOG_BUFFER_DEPTH:0] watermark_i,
  output logic [LOG_BUFFER_DEPTH:0] elements_o,
  output logic                      full_o,
  output logic                      below_wm_o,
  output logic                      wm_irq_o,
  output logic                      overflow_o,
  spi_master_tx_fifo_if.slave       bus
);
  localparam int LBD = LOG_BUFFER_DEPTH;
  localparam logic [LBD:0] DEPTH = (LBD+1)'(BUFFER_DEPTH);
  localparam logic [LBD-1:0] LAST = LBD'(BUFFER_DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [LBD-1:0] rd_ptr, wr_ptr;
  logic [LBD:0] elements, el_next;
  logic empty, push, pop, drop, byp;
  always_comb begin
    empty = elements == '0;
    full_o = elements == DEPTH;
`ifdef SPI_TXFIFO_BYPASS_EN
    byp = empty & bus.wr_i & bus.ready_i & ~clr_i;
    bus.valid_o = empty ? bus.wr_i & ~clr_i : 1'b1;
    bus.data_o = empty ? bus.wr_data_i : mem[rd_ptr];
`else
    byp = 1'b0;
    bus.valid_o = ~empty;
    bus.data_o = mem[rd_ptr];
`endif
    pop = ~empty & bus.ready_i & ~clr_i;
    // a full FIFO still takes a write when the head leaves in the same cycle
    push = bus.wr_i & ~clr_i & ~byp & (~full_o | pop);
    drop = bus.wr_i & full_o & ~pop;
    el_next = elements + (LBD+1)'(push) - (LBD+1)'(pop);
    elements_o = elements;
    below_wm_o = elements < watermark_i;
  end
  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      elements <= '0;
      overflow_o <= 1'b0;
      wm_irq_o <= 1'b0;
    end else begin
      rd_ptr <= pop ? (rd_ptr == LAST ? '0 : rd_ptr + LBD'(1)) : rd_ptr;
      wr_ptr <= push ? (wr_ptr == LAST ? '0 : wr_ptr + LBD'(1)) : wr_ptr;
      elements <= el_next;
      overflow_o <= ~ovf_clr_i & (overflow_o | drop);
      // only a net decrement can cross the threshold; an out-of-range watermark counts as always crossed
      wm_irq_o <= (el_next < elements) & (el_next < watermark_i) & ((elements >= watermark_i) | (watermark_i > DEPTH));
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.wr_data_i;
endmodule

// File: tb/tb_spi_master_tx_fifo.sv
// tb_spi_master_tx_fifo: directed stimulus with a queue scoreboard checked on every falling edge.
module tb_spi_master_tx_fifo;
  logic clk = 1'b0;
  logic rstn, clr, ovf_clr;
  logic [3:0] watermark;
  logic [3:0] elements;
  logic full, below_wm, wm_irq, overflow;
  int compared = 0;
  int mism = 0;
  logic [31:0] q[$];
  logic [5:0] exp_irq = 6'b000100;
  logic [5:0] exp_bel = 6'b111100;
  spi_master_tx_fifo_if #(.DATA_WIDTH(32)) bus ();
  spi_master_tx_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr), .ovf_clr_i(ovf_clr), .watermark_i(watermark),
    .elements_o(elements), .full_o(full), .below_wm_o(below_wm), .wm_irq_o(wm_irq),
    .overflow_o(overflow), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    bus.wr_i = w;
    bus.wr_data_i = d;
    bus.ready_i = r;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    logic was_full, do_pop;
    if (!rstn) q.delete();
    else begin
`ifdef SPI_TXFIFO_BYPASS_EN
      chk("valid", bus.valid_o, q.size() != 0 || (bus.wr_i && !clr));
`else
      chk("valid", bus.valid_o, q.size() != 0);
`endif
      chk("elements", elements, q.size());
      chk("full", full, q.size() == 8);
      if (clr) q.delete();
`ifdef SPI_TXFIFO_BYPASS_EN
      else if (q.size() == 0 && bus.wr_i && bus.ready_i) chk("byp_data", bus.data_o, bus.wr_data_i);
`endif
      else begin
        was_full = q.size() == 8;
        do_pop = q.size() != 0 && bus.ready_i;
        if (do_pop) chk("pop_data", bus.data_o, q.pop_front());
        if (bus.wr_i && (!was_full || do_pop)) q.push_back(bus.wr_data_i);
      end
    end
  end
  initial begin
    rstn = 1'b0; clr = 1'b0; ovf_clr = 1'b0; watermark = 4'd0;
    bus.wr_i = 1'b0; bus.wr_data_i = '0; bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_elements", elements, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_irq", wm_irq, 0);
    cyc(1, 32'hA1, 0); cyc(1, 32'hB2, 0); cyc(1, 32'hC3, 0);
    chk("t1_elements", elements, 3);
    chk("t1_valid", bus.valid_o, 1);
    chk("t1_head", bus.data_o, 32'hA1);
    repeat (3) cyc(0, 0, 1);
    chk("t1_empty", elements, 0);
    chk("t1_valid_lo", bus.valid_o, 0);
    for (int i = 0; i < 8; i++) cyc(1, 32'h100 + i, 0);
    chk("t2_full", full, 1);
    cyc(1, 32'hDEAD, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_head", bus.data_o, 32'h100);
    chk("t2_elements", elements, 8);
    ovf_clr = 1'b1; cyc(0, 0, 0); ovf_clr = 1'b0;
    chk("t2_ovf_clr", overflow, 0);
    ovf_clr = 1'b1; cyc(1, 32'hBEEF, 0); ovf_clr = 1'b0;
    chk("t2_clr_wins", overflow, 0);
    cyc(1, 32'h55, 1);
    chk("t3_elements", elements, 8);
    chk("t3_no_ovf", overflow, 0);
    repeat (8) cyc(0, 0, 1);
    chk("t3_drained", elements, 0);
    watermark = 4'd4;
    for (int i = 0; i < 6; i++) cyc(1, 32'h300 + i, 0);
    chk("t4_above", below_wm, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1);
      chk("t4_irq", wm_irq, exp_irq[i]);
      chk("t4_below", below_wm, exp_bel[i]);
    end
    cyc(1, 32'h350, 0); cyc(1, 32'h351, 0);
    chk("t4_below2", below_wm, 1);
    watermark = 4'd1;
    cyc(0, 0, 0);
    chk("t4_wm_change_irq", wm_irq, 0);
    chk("t4_wm_change_below", below_wm, 0);
    watermark = 4'd0;
    repeat (2) begin
      cyc(0, 0, 1);
      chk("t4_wm0_irq", wm_irq, 0);
      chk("t4_wm0_below", below_wm, 0);
    end
    watermark = 4'd15;
    cyc(1, 32'h400, 0);
    chk("t4_wmhi_below", below_wm, 1);
    cyc(0, 0, 1);
    chk("t4_wmhi_irq", wm_irq, 1);
    cyc(0, 0, 0);
    chk("t4_wmhi_irq_end", wm_irq, 0);
    watermark = 4'd0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h500 + i, (i % 3) != 0);
      chk("t5_max", elements <= 8, 1);
    end
    repeat (12) cyc(0, 0, 1);
    chk("t5_drained", elements, 0);
    watermark = 4'd5;
    for (int i = 0; i < 5; i++) cyc(1, 32'h600 + i, 0);
    chk("t6_elements", elements, 5);
    clr = 1'b1; cyc(1, 32'h6FF, 1); clr = 1'b0;
    chk("t6_elements0", elements, 0);
    chk("t6_valid", bus.valid_o, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_irq", wm_irq, 0);
    cyc(0, 0, 0);
    chk("t6_irq_after", wm_irq, 0);
`ifdef SPI_TXFIFO_BYPASS_EN
    bus.wr_i = 1'b1; bus.wr_data_i = 32'h77; bus.ready_i = 1'b1;
    #1;
    chk("byp_valid", bus.valid_o, 1);
    chk("byp_data_now", bus.data_o, 32'h77);
    @(posedge clk);
    #1 bus.wr_i = 1'b0;
    chk("byp_elements", elements, 0);
`endif
    cyc(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/spi_master_tx_fifo.md
Name: spi_master_tx_fifo

Overview:
- TX data buffer directly upstream of the SPI master controller's TX data port.
- Accepts 32-bit words from the APB register write path as non-backpressurable write strobes.
- Presents them to the controller over a valid/ready handshake.
- Reports fill level, raises a low-watermark refill interrupt pulse, and flags dropped writes with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 32, word width.
- BUFFER_DEPTH, 8, number of entries (any value ≥2; need not be a power of two).
- LOG_BUFFER_DEPTH, $clog2(BUFFER_DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- clr_i  input  1  synchronous flush.
- wr_i  input  1  write strobe from APB; one word per cycle high.
- wr_data_i  input  DATA_WIDTH  write data.
- ovf_clr_i  input  1  clears sticky overflow.
- watermark_i  input  LOG_BUFFER_DEPTH+1  refill threshold.
- data_o  output  DATA_WIDTH  head word, to controller spi_ctrl_data_tx.
- valid_o  output  1  head valid, to spi_ctrl_data_tx_valid.
- ready_i  input  1  from spi_ctrl_data_tx_ready.
- elements_o  output  LOG_BUFFER_DEPTH+1  current occupancy, 0..BUFFER_DEPTH.
- full_o  output  1  elements_o == BUFFER_DEPTH.
- below_wm_o  output  1  elements_o < watermark_i.
- wm_irq_o  output  1  one-cycle refill pulse.
- overflow_o  output  1  sticky: write dropped because full.

Behaviour:
- Reset (rstn low at a clk edge):
  - rd_ptr, wr_ptr, elements ← 0; overflow_o ← 0; wm_irq_o ← 0.
  - Hence valid_o=0, full_o=0, data_o = mem[0] (don't-care).
  - Memory contents are not reset.
- Storage: register array.
  - data_o = mem[rd_ptr] (first-word fall-through).
  - valid_o = (elements != 0).
- push = wr_i & (~full_o | pop). pop = valid_o & ready_i.
- Pointers increment on push/pop respectively and wrap from BUFFER_DEPTH-1 to 0.
- Occupancy update:
  - elements += push − pop.
  - Simultaneous push and pop leaves elements unchanged.
- Full and popping: a write in the same cycle is accepted (slot reused); no overflow.
- Full and not popping: wr_i is dropped, memory unchanged, overflow_o ← 1 next cycle.
- Empty:
  - A write becomes visible on valid_o the cycle after wr_i (latency 1).
  - A pop cannot occur in the same cycle as that write.
- overflow_o priority:
  - clr_i or ovf_clr_i clears it.
  - A simultaneous drop event and clear: clear wins.
- clr_i (priority over everything except reset):
  - Pointers and elements ← 0, overflow_o ← 0.
  - Any wr_i that cycle is discarded.
  - Any pop that cycle has no effect on state.
  - No wm_irq_o is generated by a flush.
  - Flushing mid SPI transfer is legal; the controller sees valid_o drop the next cycle.
- Watermark:
  - below_wm_o is combinational from registered elements and watermark_i.
  - wm_irq_o is registered: it pulses for one cycle when elements transitions from ≥ watermark_i to < watermark_i as a result of a pop.
  - watermark_i = 0: never below, never irq.
  - watermark_i > BUFFER_DEPTH: always below; irq on any pop leaving the count below it.
  - Changing watermark_i alone never produces a pulse.
- No combinational path from wr_i or ready_i to valid_o, data_o or elements_o (without the optional feature).

Optional Feature:
- Macro: SPI_TXFIFO_BYPASS_EN.
- Defined, when elements == 0:
  - data_o = wr_data_i and valid_o = wr_i combinationally.
  - If ready_i is high the same cycle, the word is consumed directly: not stored, pointers and elements unchanged.
  - If ready_i is low, it is stored normally.
  - Zero-latency first word; creates a wr_i→valid_o combinational path.
  - clr_i still blocks the write and forces valid_o=0.
- Undefined: behaviour exactly as above (latency 1, registered outputs only).

Test Plan:
- Reset then 3 writes (0xA1,0xB2,0xC3) with ready_i=0 → elements_o=3, valid_o=1, data_o=0xA1; then ready_i=1 for 3 cycles → pops A1,B2,C3 in order, elements_o=0, valid_o=0.
- Fill to 8 with ready_i=0, then a 9th write 0xDEAD → dropped, full_o=1, overflow_o=1 next cycle, head unchanged; ovf_clr_i pulse → overflow_o=0.
- Full, then write 0x55 while ready_i=1 → elements_o stays 8, no overflow, 0x55 emerges as the 8th word after current head.
- watermark_i=4, fill to 6, pop continuously → wm_irq_o single pulse the cycle after elements goes 4→3; below_wm_o high from elements=3; no further pulses down to 0.
- Pointer wrap: 20 interleaved write/pop cycles at depth 8 → output sequence matches input, elements_o never exceeds 8.
- elements=5, assert clr_i together with wr_i and ready_i → next cycle elements_o=0, valid_o=0, overflow_o=0, wm_irq_o=0; with SPI_TXFIFO_BYPASS_EN, empty FIFO + wr_i=1,ready_i=1 → same-cycle valid_o=1, data_o=wr_data_i, elements_o stays 0.
